// File: rtl/ifetch_pkg.sv
// Shared widths, reset PC and PC-source selection for the fetch stage.
package ifetch_pkg;

  localparam int unsigned PC_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    PC_ADVANCE  = 2'd0,
    PC_HOLD     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // A resolved flow change outranks a decode stall.
  function automatic pc_sel_e pc_select(input logic flow_change, input logic stall);
    if (flow_change) return PC_REDIRECT;
    else if (stall)  return PC_HOLD;
    else             return PC_ADVANCE;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Control inputs and fetch-side outputs of the instruction fetch stage.
interface ifetch_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned CNT_W = 16
);
  logic             stall_IM_ID;
  logic             stall_ID_EX;
  logic             flow_change_ID_EX;
  logic [PC_W-1:0]  dst_ID_EX;
  logic [PC_W-1:0]  iaddr;
  logic [PC_W-1:0]  pc_IM_ID;
  logic [PC_W-1:0]  pc_ID_EX;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall_IM_ID, stall_ID_EX, flow_change_ID_EX, dst_ID_EX,
    input  iaddr, pc_IM_ID, pc_ID_EX, fetch_cnt, redirect_cnt
  );

  modport slave (
    input  stall_IM_ID, stall_ID_EX, flow_change_ID_EX, dst_ID_EX,
    output iaddr, pc_IM_ID, pc_ID_EX, fetch_cnt, redirect_cnt
  );
endinterface

// File: rtl/ifetch_perf_cnt.sv
// Wrapping event counter with enable and async active-low reset.
module ifetch_perf_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, redirect/stall priority, next-PC pipeline
// toward decode and EX, and fetch/redirect performance counters.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned    PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int unsigned    CNT_W    = CNT_W_DEF
) (
  input logic     clk,
  input logic     rst_n,
  ifetch_if.slave fif
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] nxt_pc;
  logic [PC_W-1:0] pc_im_id_q, pc_im_id_d;
  logic [PC_W-1:0] pc_id_ex_q, pc_id_ex_d;
  pc_sel_e         pc_sel;
  logic            fetch_en;

  assign nxt_pc = pc_q + PC_W'(1);
  assign pc_sel = pc_select(fif.flow_change_ID_EX, fif.stall_IM_ID);

  always_comb begin
    pc_d       = pc_q;
    pc_im_id_d = pc_im_id_q;
    pc_id_ex_d = pc_id_ex_q;
    case (pc_sel)
      PC_REDIRECT: pc_d = fif.dst_ID_EX;
      PC_ADVANCE:  pc_d = nxt_pc;
      default:     pc_d = pc_q;
    endcase
    // Wrong-path next-PC after a redirect is flushed by decode, so no special case here.
    if (!fif.stall_IM_ID) pc_im_id_d = nxt_pc;
    if (!fif.stall_ID_EX) pc_id_ex_d = pc_im_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_im_id_q <= '0;
      pc_id_ex_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_im_id_q <= pc_im_id_d;
      pc_id_ex_q <= pc_id_ex_d;
    end
  end

  assign fetch_en = fif.flow_change_ID_EX | ~fif.stall_IM_ID;

  ifetch_perf_cnt #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (fetch_en),
    .cnt_o (fif.fetch_cnt)
  );

  ifetch_perf_cnt #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (fif.flow_change_ID_EX),
    .cnt_o (fif.redirect_cnt)
  );

  assign fif.iaddr    = pc_q;
  assign fif.pc_IM_ID = pc_im_id_q;
  assign fif.pc_ID_EX = pc_id_ex_q;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: per-cycle expected state is queued as stimulus
// is applied and compared one cycle later.
module tb_ifetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ifetch_if #(.PC_W(16), .CNT_W(16)) fif ();

  ifetch #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] iaddr;
    logic [15:0] im;
    logic [15:0] ex;
    logic [15:0] fcnt;
    logic [15:0] rcnt;
  } obs_t;

  typedef struct packed {
    logic        s_im;
    logic        s_ex;
    logic        fl;
    logic [15:0] dst;
    obs_t        exp;
  } row_t;

  obs_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  function automatic obs_t observe();
    return {fif.iaddr, fif.pc_IM_ID, fif.pc_ID_EX, fif.fetch_cnt, fif.redirect_cnt};
  endfunction

  function automatic row_t row(input logic s_im, input logic s_ex, input logic fl,
                               input logic [15:0] dst, input logic [15:0] ia,
                               input logic [15:0] im, input logic [15:0] ex,
                               input logic [15:0] fc, input logic [15:0] rc);
    return {s_im, s_ex, fl, dst, ia, im, ex, fc, rc};
  endfunction

  task automatic drive(input logic s_im, input logic s_ex, input logic fl, input logic [15:0] dst);
    fif.stall_IM_ID       = s_im;
    fif.stall_ID_EX       = s_ex;
    fif.flow_change_ID_EX = fl;
    fif.dst_ID_EX         = dst;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic advance(input int n);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    do_reset();
    sb.push_back(obs_t'(80'h0));
    e   = sb.pop_front();
    got = observe();
    chk_cnt++;
    if (got !== e) $display("FAIL reset_state: got %h expected %h", got, e);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    row_t tab[$];
    obs_t got, e;
    do_reset();
    tab.push_back(row(0,0,0,16'h0, 16'h1, 16'h1, 16'h0, 16'd1, 16'd0));
    tab.push_back(row(0,0,0,16'h0, 16'h2, 16'h2, 16'h1, 16'd2, 16'd0));
    tab.push_back(row(0,0,0,16'h0, 16'h3, 16'h3, 16'h2, 16'd3, 16'd0));
    tab.push_back(row(0,0,0,16'h0, 16'h4, 16'h4, 16'h3, 16'd4, 16'd0));
    foreach (tab[i]) begin
      drive(tab[i].s_im, tab[i].s_ex, tab[i].fl, tab[i].dst);
      sb.push_back(tab[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); got = observe(); chk_cnt++;
      if (got !== e) $display("FAIL sequence[%0d]: got %h expected %h", i, got, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    row_t tab[$];
    obs_t got, e;
    do_reset();
    advance(3);
    tab.push_back(row(1,0,0,16'h0, 16'h3, 16'h3, 16'h3, 16'd3, 16'd0));
    tab.push_back(row(1,0,0,16'h0, 16'h3, 16'h3, 16'h3, 16'd3, 16'd0));
    tab.push_back(row(1,0,0,16'h0, 16'h3, 16'h3, 16'h3, 16'd3, 16'd0));
    tab.push_back(row(0,0,0,16'h0, 16'h4, 16'h4, 16'h3, 16'd4, 16'd0));
    tab.push_back(row(0,0,0,16'h0, 16'h5, 16'h5, 16'h4, 16'd5, 16'd0));
    tab.push_back(row(0,1,0,16'h0, 16'h6, 16'h6, 16'h4, 16'd6, 16'd0));
    tab.push_back(row(0,0,0,16'h0, 16'h7, 16'h7, 16'h6, 16'd7, 16'd0));
    foreach (tab[i]) begin
      drive(tab[i].s_im, tab[i].s_ex, tab[i].fl, tab[i].dst);
      sb.push_back(tab[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); got = observe(); chk_cnt++;
      if (got !== e) $display("FAIL stall[%0d]: got %h expected %h", i, got, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    row_t tab[$];
    obs_t got, e;
    do_reset();
    advance(7);
    tab.push_back(row(0,0,1,16'h0040, 16'h0040, 16'h0008, 16'h0007, 16'd8,  16'd1));
    tab.push_back(row(0,0,0,16'h0000, 16'h0041, 16'h0041, 16'h0008, 16'd9,  16'd1));
    tab.push_back(row(0,0,0,16'h0000, 16'h0042, 16'h0042, 16'h0041, 16'd10, 16'd1));
    tab.push_back(row(0,0,1,16'h0200, 16'h0200, 16'h0043, 16'h0042, 16'd11, 16'd2));
    tab.push_back(row(0,0,1,16'h0300, 16'h0300, 16'h0201, 16'h0043, 16'd12, 16'd3));
    foreach (tab[i]) begin
      drive(tab[i].s_im, tab[i].s_ex, tab[i].fl, tab[i].dst);
      sb.push_back(tab[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); got = observe(); chk_cnt++;
      if (got !== e) $display("FAIL redirect[%0d]: got %h expected %h", i, got, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect_stall();
    row_t tab[$];
    obs_t got, e;
    do_reset();
    advance(2);
    tab.push_back(row(1,0,1,16'h0100, 16'h0100, 16'h0002, 16'h0002, 16'd3, 16'd1));
    tab.push_back(row(0,0,0,16'h0000, 16'h0101, 16'h0101, 16'h0002, 16'd4, 16'd1));
    foreach (tab[i]) begin
      drive(tab[i].s_im, tab[i].s_ex, tab[i].fl, tab[i].dst);
      sb.push_back(tab[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); got = observe(); chk_cnt++;
      if (got !== e) $display("FAIL redirect_stall[%0d]: got %h expected %h", i, got, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_and_self_redirect();
    row_t tab[$];
    obs_t got, e;
    do_reset();
    advance(1);
    tab.push_back(row(0,0,1,16'hFFFF, 16'hFFFF, 16'h0002, 16'h0001, 16'd2, 16'd1));
    tab.push_back(row(0,0,0,16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'd3, 16'd1));
    tab.push_back(row(0,0,0,16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'd4, 16'd1));
    tab.push_back(row(0,0,1,16'h0001, 16'h0001, 16'h0002, 16'h0001, 16'd5, 16'd2));
    tab.push_back(row(0,0,0,16'h0000, 16'h0002, 16'h0002, 16'h0002, 16'd6, 16'd2));
    foreach (tab[i]) begin
      drive(tab[i].s_im, tab[i].s_ex, tab[i].fl, tab[i].dst);
      sb.push_back(tab[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); got = observe(); chk_cnt++;
      if (got !== e) $display("FAIL wrap_self[%0d]: got %h expected %h", i, got, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    obs_t got, e;
    do_reset();
    advance(35);
    sb.push_back({16'h0023, 16'h0023, 16'h0022, 16'd35, 16'd0});
    e = sb.pop_front(); got = observe(); chk_cnt++;
    if (got !== e) $display("FAIL pre_reset_run: got %h expected %h", got, e);
    else pass_cnt++;

    rst_n = 1'b0;
    sb.push_back(obs_t'(80'h0));
    #1;
    e = sb.pop_front(); got = observe(); chk_cnt++;
    if (got !== e) $display("FAIL async_reset_immediate: got %h expected %h", got, e);
    else pass_cnt++;

    sb.push_back(obs_t'(80'h0));
    @(posedge clk); #1;
    e = sb.pop_front(); got = observe(); chk_cnt++;
    if (got !== e) $display("FAIL reset_held: got %h expected %h", got, e);
    else pass_cnt++;

    rst_n = 1'b1;
    sb.push_back({16'h0001, 16'h0001, 16'h0000, 16'd1, 16'd0});
    @(posedge clk); #1;
    e = sb.pop_front(); got = observe(); chk_cnt++;
    if (got !== e) $display("FAIL post_reset_first_edge: got %h expected %h", got, e);
    else pass_cnt++;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap_and_self_redirect();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
